erasure_locator_gen_p: RTL

- Parametrised successor of the erasure-locator block in the Reed-Solomon decoder.
- Builds Γ(x) = Π(1 + X_i·x) over GF(2^SYM_W) from a stream of erasure locator values X_i = α^p_i, using a valid/ready handshake.
- Tracks the erasure count and flags overflow beyond MAX_ERAS.
- Streams the finished coefficients Γ[0..count] to the key-equation / Forney stage on request, and may re-send them any number of times.

---
 rtl/erasure_locator_gen_p.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/erasure_locator_gen_p.sv
// Erasure locator polynomial builder: G(x) = prod(1 + X_i*x) over GF(2^SYM_W),
// fed by a valid/ready locator stream and read out coefficient by coefficient.
//
// Ports:
//   clock, reset (async, active low)
//   start                         : clear G to 1 and begin accumulating
//   erase_valid/ready/locator/end : locator stream and end-of-stream pulse
//   polyn_done, num_erasures      : polynomial complete, degree
//   overflow                      : sticky, locator arrived at MAX_ERAS
//   send_req                      : request coefficient readout
//   coef_valid/addr/data/last     : readout stream G[0..num_erasures]
//   coef_deriv                    : G[k+1] for even k, else 0 (optional)
//
// Optional feature macro: ERASURE_DERIV_EN adds the coef_deriv output.
module erasure_locator_gen_p #(
    parameter int SYM_W = 8,
    parameter int MAX_ERAS = 16,
    parameter int CNT_W = 5,
    parameter logic [SYM_W:0] PRIM_POLY = 9'h11D
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             erase_valid,
    output logic             erase_ready,
    input  logic [SYM_W-1:0] erase_locator,
    input  logic             erase_end,
    output logic             polyn_done,
    output logic [CNT_W-1:0] num_erasures,
    output logic             overflow,
    input  logic             send_req,
    output logic             coef_valid,
    output logic [CNT_W-1:0] coef_addr,
    output logic [SYM_W-1:0] coef_data,
    output logic             coef_last
`ifdef ERASURE_DERIV_EN
    ,
    output logic [SYM_W-1:0] coef_deriv
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE,
        SEND
    } state_t;

    state_t state_q;
    state_t state_next;

    logic [SYM_W-1:0] gamma      [0:MAX_ERAS];
    logic [SYM_W-1:0] gamma_next [0:MAX_ERAS];
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             accept;
    logic [CNT_W-1:0] send_k;
    logic [SYM_W-1:0] sel_data;
`ifdef ERASURE_DERIV_EN
    logic [SYM_W-1:0] sel_deriv;
`endif

    function automatic logic [SYM_W-1:0] gf_mul(
        input logic [SYM_W-1:0] a,
        input logic [SYM_W-1:0] b
    );
        logic [SYM_W-1:0] p;
        logic [SYM_W-1:0] aa;
        logic             carry;
        p  = '0;
        aa = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) p = p ^ aa;
            carry = aa[SYM_W-1];
            aa    = aa << 1;
            if (carry) aa = aa ^ PRIM_POLY[SYM_W-1:0];
        end
        return p;
    endfunction

    assign num_erasures = count_q;
    assign overflow     = ovf_q;

    // A start in the same cycle discards any transfer.
    assign accept = (state_q == ACCUM) && erase_valid && erase_ready && !start;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (erase_end) state_next = DONE;
            DONE:    if (send_req) state_next = SEND;
            SEND:    if (coef_last) state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (start) state_next = ACCUM;
    end

    // Multiply G by (1 + X*x): each coefficient picks up X times its lower neighbour.
    always_comb begin
        gamma_next[0] = gamma[0];
        for (int k = 1; k <= MAX_ERAS; k++) begin
            gamma_next[k] = gamma[k] ^ gf_mul(erase_locator, gamma[k-1]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gamma[0] <= SYM_W'(1);
            for (int k = 1; k <= MAX_ERAS; k++) gamma[k] <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (start) begin
            gamma[0] <= SYM_W'(1);
            for (int k = 1; k <= MAX_ERAS; k++) gamma[k] <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            if (count_q == CNT_W'(MAX_ERAS)) begin
                ovf_q <= 1'b1;
            end else if (erase_locator != '0) begin
                for (int k = 0; k <= MAX_ERAS; k++) gamma[k] <= gamma_next[k];
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Index of the coefficient presented on the next cycle of a readout.
    assign send_k = (state_q == SEND) ? coef_addr + CNT_W'(1) : '0;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i <= MAX_ERAS; i++) begin
            if (CNT_W'(i) == send_k) sel_data = gamma[i];
        end
    end

`ifdef ERASURE_DERIV_EN
    // Char-2 formal derivative: only odd-degree terms survive, shifted down.
    always_comb begin
        sel_deriv = '0;
        for (int i = 0; i < MAX_ERAS; i += 2) begin
            if (CNT_W'(i) == send_k) sel_deriv = gamma[i+1];
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            erase_ready <= 1'b0;
            polyn_done  <= 1'b0;
            coef_valid  <= 1'b0;
            coef_addr   <= '0;
            coef_data   <= '0;
            coef_last   <= 1'b0;
`ifdef ERASURE_DERIV_EN
            coef_deriv  <= '0;
`endif
        end else begin
            erase_ready <= (state_next == ACCUM);
            polyn_done  <= (state_next == DONE) || (state_next == SEND);
            if (state_next == SEND) begin
                coef_valid <= 1'b1;
                coef_addr  <= send_k;
                coef_data  <= sel_data;
                coef_last  <= (send_k == count_q);
`ifdef ERASURE_DERIV_EN
                coef_deriv <= sel_deriv;
`endif
            end else begin
                coef_valid <= 1'b0;
                coef_addr  <= '0;
                coef_data  <= '0;
                coef_last  <= 1'b0;
`ifdef ERASURE_DERIV_EN
                coef_deriv <= '0;
`endif
            end
        end
    end

endmodule
